// File: rtl/gdo.sv
// Shared definitions for the gradient-descent weight bank: FSM states,
// saturating subtraction and packed-row lane slicing.
package gdo;

  localparam int MAX_W   = 32;
  localparam int MAX_BUS = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic logic signed [MAX_W:0] gdo_sub(input logic signed [MAX_W-1:0] a,
                                                     input logic signed [MAX_W-1:0] b);
    return {a[MAX_W-1], a} - {b[MAX_W-1], b};
  endfunction

  // Exact difference, then clamp into the signed range of 'width' bits.
  function automatic logic signed [MAX_W-1:0] sat_sub(input logic signed [MAX_W-1:0] a,
                                                      input logic signed [MAX_W-1:0] b,
                                                      input int width);
    logic signed [MAX_W:0] diff;
    logic signed [MAX_W:0] one;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    logic signed [MAX_W:0] r;
    diff = gdo_sub(a, b);
    one  = 1;
    hi   = (one <<< (width - 1)) - one;
    lo   = -(one <<< (width - 1));
    if (diff > hi)      r = hi;
    else if (diff < lo) r = lo;
    else                r = diff;
    return r[MAX_W-1:0];
  endfunction

  // Lane 0 sits in the most significant bits; result is sign-extended.
  function automatic logic signed [MAX_W-1:0] lane_get(input logic [MAX_BUS-1:0] bus,
                                                       input int lane,
                                                       input int width,
                                                       input int lanes);
    logic [MAX_BUS-1:0]    sh;
    logic signed [MAX_W-1:0] t;
    sh = bus >> ((lanes - 1 - lane) * width);
    t  = sh[MAX_W-1:0];
    t  = t <<< (MAX_W - width);
    t  = t >>> (MAX_W - width);
    return t;
  endfunction

endpackage

// File: rtl/weight_lane_update.sv
// One lane of the gradient step: sat(w - (g >>> LR_SHIFT)).
module weight_lane_update
  import gdo::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int LR_SHIFT  = 0
) (
  input  logic signed [DATA_SIZE-1:0] w,
  input  logic signed [DATA_SIZE-1:0] g,
  output logic signed [DATA_SIZE-1:0] result
);

  logic signed [DATA_SIZE-1:0] g_sh;

  assign g_sh   = g >>> LR_SHIFT;
  assign result = DATA_SIZE'(sat_sub(MAX_W'(w), MAX_W'(g_sh), DATA_SIZE));

endmodule

// File: rtl/weight_bank.sv
// Layered weight memory with 1-cycle reads, row writes, saturating
// gradient updates and a row-per-cycle clear sequencer.
module weight_bank
  import gdo::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int COL_SIZE   = 3,
  parameter int ROW_SIZE   = 3,
  parameter int LAYER_SIZE = 5,
  parameter int LR_SHIFT   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_en,
  input  logic [31:0]                     rd_layer,
  input  logic [31:0]                     rd_row,
  output logic [DATA_SIZE*COL_SIZE-1:0]   rd_data,
  output logic                            rd_valid,
  input  logic                            wr_en,
  input  logic [31:0]                     wr_layer,
  input  logic [31:0]                     wr_row,
  input  logic [DATA_SIZE*COL_SIZE-1:0]   wr_data,
  input  logic                            upd_en,
  input  logic [31:0]                     upd_layer,
  input  logic [31:0]                     upd_row,
  input  logic [DATA_SIZE*COL_SIZE-1:0]   upd_grad,
  input  logic                            clr_start,
  output logic                            busy,
  output logic                            err_range,
  output logic                            collision
);

  localparam int ROW_W = DATA_SIZE * COL_SIZE;
  localparam int DEPTH = LAYER_SIZE * ROW_SIZE;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [ROW_W-1:0] row_t;

  row_t             mem_q [DEPTH];
  row_t             mem_d [DEPTH];
  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  row_t             rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_range_q, err_range_d;
  logic             collision_q, collision_d;

  logic             rd_in, wr_in, upd_in;
  logic             rd_ok, wr_ok, upd_ok, same_row;
  logic [IDX_W-1:0] rd_idx, wr_idx, upd_idx;
  row_t             upd_row_new;

  function automatic logic in_range(input logic [31:0] l, input logic [31:0] r);
    return (l < 32'(LAYER_SIZE)) && (r < 32'(ROW_SIZE));
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [31:0] l, input logic [31:0] r);
    logic [31:0] flat;
    flat = l * 32'(ROW_SIZE) + r;
    return flat[IDX_W-1:0];
  endfunction

  assign busy     = (state_q == CLEAR);
  assign rd_in    = in_range(rd_layer, rd_row);
  assign wr_in    = in_range(wr_layer, wr_row);
  assign upd_in   = in_range(upd_layer, upd_row);
  assign rd_ok    = rd_en && !busy && rd_in;
  assign wr_ok    = wr_en && !busy && wr_in;
  assign upd_ok   = upd_en && !busy && upd_in;
  assign same_row = (wr_layer == upd_layer) && (wr_row == upd_row);
  assign rd_idx   = rd_ok  ? to_idx(rd_layer, rd_row)   : '0;
  assign wr_idx   = wr_ok  ? to_idx(wr_layer, wr_row)   : '0;
  assign upd_idx  = upd_ok ? to_idx(upd_layer, upd_row) : '0;

  for (genvar c = 0; c < COL_SIZE; c++) begin : g_lane
    logic signed [DATA_SIZE-1:0] w_lane, g_lane, n_lane;
    assign w_lane = DATA_SIZE'(lane_get(MAX_BUS'(mem_q[upd_idx]), c, DATA_SIZE, COL_SIZE));
    assign g_lane = DATA_SIZE'(lane_get(MAX_BUS'(upd_grad), c, DATA_SIZE, COL_SIZE));
    weight_lane_update #(
      .DATA_SIZE(DATA_SIZE),
      .LR_SHIFT (LR_SHIFT)
    ) u_lane (
      .w     (w_lane),
      .g     (g_lane),
      .result(n_lane)
    );
    assign upd_row_new[(COL_SIZE-1-c)*DATA_SIZE +: DATA_SIZE] = n_lane;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_valid_d  = rd_ok;
    rd_data_d   = rd_ok ? mem_q[rd_idx] : '0;
    err_range_d = !busy && ((rd_en && !rd_in) || (wr_en && !wr_in) || (upd_en && !upd_in));
    collision_d = wr_ok && upd_ok && same_row;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Write is applied after the update so it wins on a shared row.
  always_comb begin
    mem_d = mem_q;
    if (busy) begin
      mem_d[cnt_q] = '0;
    end else begin
      if (upd_ok && !collision_d) mem_d[upd_idx] = upd_row_new;
      if (wr_ok)                  mem_d[wr_idx]  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_range_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      err_range_q <= err_range_d;
      collision_q <= collision_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err_range = err_range_q;
  assign collision = collision_q;

endmodule

// File: doc/weight_bank.md
WEIGHT_BANK -- requirements
Module: weight_bank

Interface
REQ-001 Parameter DATA_SIZE, default 16: signed weight width in bits.
REQ-002 Parameter COL_SIZE, default 3: weights per row, which is also the word lanes per port.
REQ-003 Parameter ROW_SIZE, default 3: rows per layer.
REQ-004 Parameter LAYER_SIZE, default 5: number of layers.
REQ-005 Parameter LR_SHIFT, default 0: learning-rate arithmetic right shift applied to gradients.
REQ-006 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port rd_en / rd_layer / rd_row, input, 1 / 32 / 32: read request and its address.
REQ-009 Port rd_data, output, DATA_SIZE*COL_SIZE: row read result; lane 0 in the most significant bits.
REQ-010 Port rd_valid, output, 1: rd_data is valid this cycle.
REQ-011 Port wr_en / wr_layer / wr_row / wr_data, input, 1 / 32 / 32 / DATA_SIZE*COL_SIZE: row overwrite; lane 0 in the most significant bits.
REQ-012 Port upd_en / upd_layer / upd_row / upd_grad, input, 1 / 32 / 32 / DATA_SIZE*COL_SIZE: gradient-descent update of one row.
REQ-013 Port clr_start, input, 1: begin a full-memory clear.
REQ-014 Port busy, output, 1: a clear is in progress.
REQ-015 Port err_range, output, 1: single-cycle pulse when any enabled request carries an out-of-range index.
REQ-016 Port collision, output, 1: single-cycle pulse when a write and an update target the same row in the same cycle.

Function
REQ-017 Storage SHALL hold LAYER_SIZE x ROW_SIZE rows, each COL_SIZE signed DATA_SIZE-bit weights.
REQ-018 Reads SHALL have 1-cycle latency: a request accepted at edge N presents rd_data and rd_valid=1 after edge N; otherwise rd_valid=0.
REQ-019 When rd_valid=0, rd_data SHALL be 0.
REQ-020 Reads SHALL be read-first: a same-edge write or update to the read row is not visible in that read.
REQ-021 Write: each lane of the row SHALL be set to the corresponding wr_data lane.
REQ-022 Update: each lane SHALL become sat(w - (g >>> LR_SHIFT)), computed at DATA_SIZE+1 bits and clamped to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
REQ-023 A write and an update to different rows in the same cycle SHALL both take effect.
REQ-024 A write and an update to the same layer/row in the same cycle: the write SHALL win, the update is dropped, and collision SHALL pulse.
REQ-025 A request with layer >= LAYER_SIZE or row >= ROW_SIZE SHALL be ignored and SHALL pulse err_range; for a read, rd_valid stays 0.
REQ-026 FSM states SHALL be IDLE and CLEAR.
REQ-027 IDLE -> CLEAR on clr_start.
REQ-028 In CLEAR, a row counter SHALL zero one row per cycle, layer-major, and return to IDLE after LAYER_SIZE*ROW_SIZE cycles.
REQ-029 busy SHALL be 1 exactly while in CLEAR.
REQ-030 While busy, rd_en, wr_en, upd_en and clr_start SHALL be ignored, with no err_range pulse.

Reset
REQ-031 rst SHALL force state CLEAR, row counter 0, and rd_valid, rd_data, err_range and collision to 0.
REQ-032 On release of rst, the bank SHALL complete a full clear (busy=1 for LAYER_SIZE*ROW_SIZE cycles) before accepting requests.
REQ-033 Asserting rst mid-operation SHALL abort any clear and restart it from row 0.

Structure
REQ-034 The saturating subtract function, the state enum and the lane-slicing helper SHALL live in the shared package gdo, alongside the existing gdo_sub.
REQ-035 One sub-module, weight_lane_update, SHALL compute the shifted saturating subtraction for one lane and be instantiated COL_SIZE times.

Verification
REQ-036 Reset, then wait 15 cycles -> busy=1 for exactly 15 cycles; reading layer 4 row 2 afterwards -> rd_data=0, rd_valid=1 one cycle later.
REQ-037 Write layer 1 row 2 = {5, -3, 100}, read it next cycle -> rd_data={5, -3, 100} after 1 cycle; a same-cycle read of that row returns the old value.
REQ-038 Row = {32767, -32768, 10}, update grad {-1, 1, 4} -> {32767, -32768, 6}; with LR_SHIFT=2 and grad 4 on lane 2 -> lane 2 = 9.
REQ-039 Write and update to layer 0 row 0 in the same cycle -> write value stored, collision=1 for one cycle; same stimulus on different rows -> both applied, collision=0.
REQ-040 Read layer 5 row 0 -> err_range=1 for one cycle, rd_valid=0, memory unchanged.
REQ-041 Assert clr_start, then assert rst after 4 cycles -> the clear restarts, busy=1 for 15 cycles after rst deasserts, and all rows read 0.
